maze_link_rx: RTL
=================

// Module: maze_link_rx
// PURPOSE
//  Receives maze-cell updates from the Arduino over the 9-pin parallel GPIO_1 bus: 3 data, 1 strobe, 5 address.
//  Resynchronises the bus into the 25 MHz CLOCK domain and assembles three 3-bit beats into one 9-bit cell word.
//  Issues a single-cycle write into the VGA cell RAM, which the pixel renderer reads. Also raises DONE for the DDS tone stage.
//  Replaces the practice of clocking logic directly from the Arduino strobe.
// PARAMETERS
//  CELLS        20      number of valid cell addresses (0..CELLS-1)
//  SYNC_STAGES  2       flip-flop depth of the input synchroniser (>=2)
//  TIMEOUT      250000  CLOCK cycles allowed between beats of one frame (10 ms at 25 MHz)
//  ERR_W        8       width of the saturating error counter
// PORTS
//  CLOCK         in   1      25 MHz system clock; all logic is on its rising edge
//  RESET         in   1      synchronous, active-high reset
//  ARD_DATA      in   3      async data beat, GPIO_1_D[25,23,21]
//  ARD_STROBE    in   1      async beat strobe, GPIO_1_D[19]; rising edge = beat valid
//  ARD_ADDR      in   5      async address, GPIO_1_D[17..9]; 31 = SYNC, 30 = DONE
//  RAM_WADDR     out  5      cell RAM write address
//  RAM_WDATA     out  9      cell word {state[8:6], walls N/E/S/W[5:2], treasure[1:0]}
//  RAM_WE        out  1      write enable, one-cycle pulse
//  DONE          out  1      maze-complete level for the DDS stage
//  BUSY          out  1      high while a frame is in progress (any WAIT_* state)
//  ERR_CNT       out  ERR_W  saturating count of aborted or illegal frames
// BEHAVIOUR
//  - Reset values: RAM_WADDR=0, RAM_WDATA=0, RAM_WE=0, DONE=0, BUSY=0, ERR_CNT=0, FSM=IDLE, timer=0.
//  - Input path: all 9 bus bits pass through SYNC_STAGES flip-flops. A beat is the cycle E in which the
//    synchronised strobe is 1 and was 0 in the previous cycle. Address and data are taken from the
//    synchronised copies in cycle E.
//  - Arduino contract: bus stable for >= SYNC_STAGES+2 cycles on each side of the strobe rising edge.
//  - Frame format: SYNC beat (addr 31), then LO, MID, HI beats, all carrying the same cell address.
//    Data bits land as LO->[2:0], MID->[5:3], HI->[8:6].
//  - FSM:
//    IDLE:     SYNC -> WAIT_LO. DONE beat -> DONE=1, stay. Any other beat -> ignored, no error.
//    WAIT_LO:  addr < CELLS -> latch addr and LO -> WAIT_MID. addr in CELLS..29 -> error, go to IDLE.
//    WAIT_MID: same addr -> latch MID -> WAIT_HI. Different addr (not 30/31) -> error, go to IDLE.
//    WAIT_HI:  same addr -> latch HI. At E+1: RAM_WE=1, RAM_WADDR/RAM_WDATA = the assembled word; go to IDLE.
//              Different addr -> error, go to IDLE. No write occurs.
//    Any WAIT_*:
//      SYNC beat -> error, restart in WAIT_LO; the partial word is discarded.
//      DONE beat -> error, set DONE=1, go to IDLE.
//  - DONE stays 1 until the next SYNC beat is accepted, which clears it in that same cycle, or until RESET.
//  - Latency: beat E -> RAM_WE at E+1. Raw strobe edge -> RAM_WE in SYNC_STAGES+2 cycles.
//    RAM_WADDR and RAM_WDATA hold their values after the pulse.
//  - Timeout: the timer clears on every beat and counts in WAIT_* states.
//    Reaching TIMEOUT-1 -> error, go to IDLE. If a beat and the timeout occur in the same cycle, the beat wins.
//  - ERR_CNT increments by 1 per error and saturates at all-ones (no wrap).
//  - RESET asserted mid-frame: the FSM returns to IDLE on the next edge, the partial word is dropped,
//    and no RAM_WE is issued.
//  - RAM_WE and RESET in the same cycle: reset wins and RAM_WE=0.
//  - BUSY is a registered decode of the FSM state.
// STRUCTURE
//  - Shared include maze_defs.vh holds: ADDR_SYNC=31, ADDR_DONE=30, cell-word field positions,
//    state codes (unvisited, visited, unreachable, robot N/E/S/W) and treasure codes.
//    The renderer uses the same include.
//  - Sub-module arduino_bus_sync: parameterised-width synchroniser plus strobe rising-edge detector.
//    Outputs the synced bus and a beat pulse.
//  - This block contains the FSM, beat assembler, timeout timer, error counter and output registers.
// TESTING
//  1. Send SYNC, then addr 7 with data 3'b101, 3'b011, 3'b001 -> exactly one RAM_WE,
//     RAM_WADDR=7, RAM_WDATA=9'b001_011_101, at SYNC_STAGES+2 cycles after the HI strobe.
//  2. Send SYNC, then addr 4 LO, then addr 5 MID -> no RAM_WE, ERR_CNT=1, BUSY=0.
//     A following full frame to addr 5 writes correctly.
//  3. Send SYNC, then addr 2 LO, then stall for TIMEOUT cycles -> ERR_CNT=1, FSM=IDLE.
//     A late MID beat produces no write.
//  4. Send a DONE beat in IDLE -> DONE=1 and no ERR increment. The next SYNC clears DONE to 0.
//  5. Send SYNC, addr 9 LO, then SYNC again, then a full frame to addr 9 -> ERR_CNT=1,
//     one write containing only the second frame's data.
//  6. Pulse RESET between the MID and HI beats -> no RAM_WE, all outputs return to their reset values.
//     Force 300 errors with ERR_W=8 -> ERR_CNT=255.

Source files
------------

// File: rtl/maze_link_rx_pkg.sv
// Shared maze-link definitions: control addresses, cell-word layout, cell/treasure codes, receiver states.
package maze_link_rx_pkg;

  localparam logic [4:0] ADDR_SYNC = 5'd31;
  localparam logic [4:0] ADDR_DONE = 5'd30;

  localparam int unsigned BEAT_W = 3;
  localparam int unsigned WORD_W = 3 * BEAT_W;
  localparam int unsigned ADDR_W = 5;

  // Cell word field positions: {state[8:6], walls N/E/S/W[5:2], treasure[1:0]}
  localparam int unsigned F_STATE_LSB    = 6;
  localparam int unsigned F_WALL_N       = 5;
  localparam int unsigned F_WALL_E       = 4;
  localparam int unsigned F_WALL_S       = 3;
  localparam int unsigned F_WALL_W       = 2;
  localparam int unsigned F_TREASURE_LSB = 0;

  typedef enum logic [2:0] {
    CELL_UNVISITED   = 3'd0,
    CELL_VISITED     = 3'd1,
    CELL_UNREACHABLE = 3'd2,
    CELL_ROBOT_N     = 3'd3,
    CELL_ROBOT_E     = 3'd4,
    CELL_ROBOT_S     = 3'd5,
    CELL_ROBOT_W     = 3'd6
  } cell_state_e;

  typedef enum logic [1:0] {
    TREASURE_NONE  = 2'd0,
    TREASURE_RED   = 2'd1,
    TREASURE_GREEN = 2'd2,
    TREASURE_BLUE  = 2'd3
  } treasure_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_LO  = 2'd1,
    ST_WAIT_MID = 2'd2,
    ST_WAIT_HI  = 2'd3
  } rx_state_e;

  function automatic logic is_ctrl_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_SYNC) || (a == ADDR_DONE);
  endfunction

endpackage

// File: rtl/maze_link_rx_bus_sync.sv
// Arduino bus synchroniser: SYNC_STAGES-deep flop chain on every bus bit plus a registered
// strobe rising-edge detector. The synced bus is registered alongside the beat pulse so the
// address/data seen with beat_o belong to the same cycle.
module arduino_bus_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] bus_i,
  input  logic             strobe_i,
  output logic [WIDTH-1:0] bus_o,
  output logic             beat_o
);

  logic [WIDTH-1:0] bus_sync_q    [STAGES];
  logic             strobe_sync_q [STAGES];
  logic             strobe_prev_q;

  // Synchroniser chain, edge detector and aligned output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        bus_sync_q[i]    <= '0;
        strobe_sync_q[i] <= 1'b0;
      end
      strobe_prev_q <= 1'b0;
      bus_o         <= '0;
      beat_o        <= 1'b0;
    end else begin
      bus_sync_q[0]    <= bus_i;
      strobe_sync_q[0] <= strobe_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        bus_sync_q[i]    <= bus_sync_q[i-1];
        strobe_sync_q[i] <= strobe_sync_q[i-1];
      end
      strobe_prev_q <= strobe_sync_q[STAGES-1];
      bus_o         <= bus_sync_q[STAGES-1];
      beat_o        <= strobe_sync_q[STAGES-1] & ~strobe_prev_q;
    end
  end

endmodule

// File: rtl/maze_link_rx.sv
// Maze-link receiver: assembles SYNC + LO/MID/HI beats into a 9-bit cell word and writes it
// into the VGA cell RAM; also tracks DONE, frame timeout and a saturating error count.
module maze_link_rx
  import maze_link_rx_pkg::*;
#(
  parameter int unsigned CELLS       = 20,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 250000,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [2:0]       ARD_DATA,
  input  logic             ARD_STROBE,
  input  logic [4:0]       ARD_ADDR,
  output logic [4:0]       RAM_WADDR,
  output logic [8:0]       RAM_WDATA,
  output logic             RAM_WE,
  output logic             DONE,
  output logic             BUSY,
  output logic [ERR_W-1:0] ERR_CNT
);

  localparam int unsigned       TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [ADDR_W+BEAT_W-1:0] bus_s;
  logic                     beat;
  logic [ADDR_W-1:0]        addr_s;
  logic [BEAT_W-1:0]        data_s;

  rx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              err_inc;

  arduino_bus_sync #(
    .WIDTH  (ADDR_W + BEAT_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i    (CLOCK),
    .rst_i    (RESET),
    .bus_i    ({ARD_ADDR, ARD_DATA}),
    .strobe_i (ARD_STROBE),
    .bus_o    (bus_s),
    .beat_o   (beat)
  );

  assign addr_s = bus_s[ADDR_W+BEAT_W-1:BEAT_W];
  assign data_s = bus_s[BEAT_W-1:0];

  // Frame FSM, beat assembler, timeout timer and error/next-output computation
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    timer_d = timer_q;
    done_d  = done_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_inc = 1'b0;

    // A beat always takes priority over a timeout landing in the same cycle.
    if (beat) begin
      timer_d = '0;
      if (addr_s == ADDR_SYNC) begin
        done_d  = 1'b0;
        word_d  = '0;
        state_d = ST_WAIT_LO;
        err_inc = (state_q != ST_IDLE);
      end else if (addr_s == ADDR_DONE) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        err_inc = (state_q != ST_IDLE);
      end else begin
        unique case (state_q)
          ST_IDLE: ;
          ST_WAIT_LO: begin
            if (32'(addr_s) < CELLS) begin
              addr_d      = addr_s;
              word_d[2:0] = data_s;
              state_d     = ST_WAIT_MID;
            end else begin
              err_inc = 1'b1;
              state_d = ST_IDLE;
            end
          end
          ST_WAIT_MID: begin
            if (addr_s == addr_q) begin
              word_d[5:3] = data_s;
              state_d     = ST_WAIT_HI;
            end else begin
              err_inc = 1'b1;
              state_d = ST_IDLE;
            end
          end
          ST_WAIT_HI: begin
            if (addr_s == addr_q) begin
              word_d[8:6] = data_s;
              we_d        = 1'b1;
              waddr_d     = addr_q;
              wdata_d     = {data_s, word_q[5:0]};
            end else begin
              err_inc = 1'b1;
            end
            state_d = ST_IDLE;
          end
        endcase
      end
    end else if (state_q != ST_IDLE) begin
      if (timer_q == TMR_LAST) begin
        err_inc = 1'b1;
        state_d = ST_IDLE;
        timer_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    err_d = err_q;
    if (err_inc && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset overrides any pending write
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      timer_q <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign RAM_WADDR = waddr_q;
  assign RAM_WDATA = wdata_q;
  assign RAM_WE    = we_q;
  assign DONE      = done_q;
  assign BUSY      = busy_q;
  assign ERR_CNT   = err_q;

endmodule
